// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: FSM encoding, band codes and
// band thresholds. The PWM generator and the LCD path use the same band codes.
package pwm_duty_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meter_state_e;

  typedef enum logic [1:0] {
    BAND_20  = 2'd0,
    BAND_50  = 2'd1,
    BAND_80  = 2'd2,
    BAND_OFF = 2'd3
  } band_e;

  localparam logic [6:0] BAND_TH_OFF = 7'd10;
  localparam logic [6:0] BAND_TH_50  = 7'd35;
  localparam logic [6:0] BAND_TH_80  = 7'd65;
  localparam logic [6:0] DUTY_MAX    = 7'd100;

  // Boundary values belong to the higher band.
  function automatic band_e band_of(input logic [6:0] duty);
    if (duty < BAND_TH_OFF)     band_of = BAND_OFF;
    else if (duty < BAND_TH_50) band_of = BAND_20;
    else if (duty < BAND_TH_80) band_of = BAND_50;
    else                        band_of = BAND_80;
  endfunction

endpackage

// File: rtl/pwm_duty_meter_div.sv
// Sequential restoring divider: one quotient bit per cycle, CNT_W+7 cycles.
// done pulses for one cycle with the final quotient; abort drops the divide.
module pwm_div #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W+6:0]   dividend,
  input  logic [CNT_W-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [CNT_W+6:0]   quotient
);

  localparam int DW = CNT_W + 7;
  localparam int CW = $clog2(DW + 1);

  logic [CNT_W-1:0] r_rem;
  logic [DW-1:0]    r_quo;
  logic [CNT_W-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0]   w_shift;
  logic [CNT_W+1:0] w_diff;
  logic [CNT_W-1:0] w_rem_nx;
  logic             w_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_shift  = {r_rem, r_quo[DW-1]};
    w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
    w_bit    = ~w_diff[CNT_W+1];
    w_rem_nx = w_bit ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
  end

  // Iteration control; the remainder never exceeds the divisor width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_quo <= {r_quo[DW-2:0], w_bit};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        r_quo  <= dividend;
        r_rem  <= '0;
        r_dvs  <= divisor;
        r_cnt  <= CW'(DW);
        r_busy <= 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM receive-side meter: period, high time, duty percent and humidity band.
// Counts rise-to-rise in clk cycles, divides hi*100/period in a sequential
// divider, and reports a stuck line after TIMEOUT cycles without an edge.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic [1:0]       band,
  output logic             meas_valid,
  output logic             stuck,
  output logic             overrun
);

  localparam int DW = CNT_W + 7;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_lvl, w_rise, w_fall;

  meter_state_e     r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_hi, w_hi_nx;
  logic             w_meas_done, w_timeout, w_to_lvl;

  logic [CNT_W-1:0] r_lat_per, r_lat_hi;
  logic             w_div_start, w_div_busy, w_div_done;
  logic [DW-1:0]    w_dividend, w_quo;
  logic [6:0]       w_duty;

  logic [CNT_W-1:0] r_period, r_high;
  logic [6:0]       r_duty;
  band_e            r_band;
  logic             r_valid, r_stuck, r_overrun;

  // Synchronizer plus one edge-detect register; edges are unfiltered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  // FSM state, running count and captured high time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hi    <= w_hi_nx;
    end
  end

  // Next state; an edge beats a timeout in the same cycle, and the count is
  // restarted before it can reach TIMEOUT+1, so it never wraps.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_hi_nx     = r_hi;
    w_meas_done = 1'b0;
    w_timeout   = 1'b0;
    w_to_lvl    = w_lvl;
    if (!enable) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_ARM;
          w_cnt_nx   = '0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nx = ST_HIGH;
            w_cnt_nx   = CNT_W'(1);
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            w_timeout  = 1'b1;
            w_state_nx = ST_ARM;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_hi_nx    = r_cnt;
            w_state_nx = ST_LOW;
            w_cnt_nx   = r_cnt + CNT_W'(1);
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            w_timeout  = 1'b1;
            w_to_lvl   = 1'b1;
            w_state_nx = ST_ARM;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_meas_done = 1'b1;
            w_state_nx  = ST_HIGH;
            w_cnt_nx    = CNT_W'(1);
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            w_timeout  = 1'b1;
            w_to_lvl   = 1'b0;
            w_state_nx = ST_ARM;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  assign w_div_start = w_meas_done & ~w_div_busy;
  assign w_dividend  = DW'(r_hi) * DW'(100);
  assign w_duty      = (w_quo > DW'(DUTY_MAX)) ? DUTY_MAX : w_quo[6:0];

  pwm_div #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .abort    (~enable),
    .dividend (w_dividend),
    .divisor  (r_cnt),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  // Result publishing; operands are latched at divider start so a new
  // measurement in the done cycle cannot blend into the published result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_per <= '0;
      r_lat_hi  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_duty    <= '0;
      r_band    <= BAND_20;
      r_valid   <= 1'b0;
      r_stuck   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_timeout) begin
        r_period <= CNT_W'(TIMEOUT);
        r_high   <= w_to_lvl ? CNT_W'(TIMEOUT) : '0;
        r_duty   <= w_to_lvl ? DUTY_MAX : 7'd0;
        r_band   <= w_to_lvl ? BAND_80 : BAND_OFF;
        r_stuck  <= 1'b1;
        r_valid  <= 1'b1;
      end else if (w_div_done && enable) begin
        r_period <= r_lat_per;
        r_high   <= r_lat_hi;
        r_duty   <= w_duty;
        r_band   <= band_of(w_duty);
        r_stuck  <= 1'b0;
        r_valid  <= 1'b1;
      end
      if (w_div_start) begin
        r_lat_per <= r_cnt;
        r_lat_hi  <= r_hi;
      end
      if (w_meas_done && w_div_busy) r_overrun <= 1'b1;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign duty_pct   = r_duty;
  assign band       = r_band;
  assign meas_valid = r_valid;
  assign stuck      = r_stuck;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus pushes hand-computed results
// per completed period; a negedge monitor pops and compares on meas_valid.
module tb_pwm_duty_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4095;

  typedef struct {
    int per;
    int hi;
    int duty;
    int bnd;
    bit stk;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty_pct;
  logic [1:0]       band;
  logic             meas_valid, stuck, overrun;

  int   total = 0;
  int   bad = 0;
  int   x_bad = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t prev, fixed, last_exp, me;
  bit   prev_valid = 0;
  bit   fixed_on = 0;
  int   n_phase = 0;
  int   last_cyc = 0;

  always #5 clk = ~clk;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .duty_pct   (duty_pct),
    .band       (band),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", nm, got, want);
    end
  endtask

  task automatic chk_min(input string nm, input int got, input int want);
    total++;
    if (got < want) begin
      bad++;
      $display("FAIL %s: got %0d, need at least %0d", nm, got, want);
    end
  endtask

  task automatic chk_res(input string nm, input exp_t e);
    total++;
    if (int'(period) != e.per || int'(high_time) != e.hi || int'(duty_pct) != e.duty ||
        int'(band) != e.bnd || stuck != e.stk) begin
      bad++;
      $display("FAIL %s: got per=%0d hi=%0d duty=%0d band=%0d stuck=%0d, need per=%0d hi=%0d duty=%0d band=%0d stuck=%0d",
               nm, period, high_time, duty_pct, band, stuck, e.per, e.hi, e.duty, e.bnd, e.stk);
    end
  endtask

  // Leaves time 1 unit after a rising edge so pin changes never race the flops.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PWM period starting with a rise; the rise completes the previous period.
  task automatic pwm_period(input int per, input int hi, input int duty, input int bnd);
    if (prev_valid) q.push_back(prev);
    prev       = '{per, hi, duty, bnd, 1'b0};
    prev_valid = 1;
    pwm_in = 1'b1;
    wait_cyc(hi);
    pwm_in = 1'b0;
    wait_cyc(per - hi);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high"}, int'(high_time), 0);
    chk({tag, "_duty"}, int'(duty_pct), 0);
    chk({tag, "_band"}, int'(band), 0);
    chk({tag, "_valid"}, int'(meas_valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Monitor: queued results first, then the fixed expectation of a phase.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if ($isunknown({period, high_time, duty_pct, band, meas_valid, stuck, overrun})) x_bad++;
    if (rst && meas_valid) begin
      if (q.size() != 0) begin
        me = q.pop_front();
        chk_res("result", me);
        last_exp = me;
      end else if (fixed_on) begin
        chk_res("phase_result", fixed);
        if (fixed.stk && n_phase > 0) chk("stuck_spacing", cyc - last_cyc, TIMEOUT + 1);
        n_phase++;
        last_cyc = cyc;
        last_exp = fixed;
      end else begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got meas_valid=1 at cycle %0d, need none", cyc);
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got no finish, need finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cyc(5);
    chk_zero("reset");
    rst = 1'b1;
    wait_cyc(3);
    enable = 1'b1;
    wait_cyc(50);

    // Continuous stream; each pattern change must report clean values.
    repeat (5) pwm_period(1000, 199, 19, 0);
    repeat (3) pwm_period(1000, 799, 79, 2);
    repeat (3) pwm_period(1000, 500, 50, 1);
    repeat (2) pwm_period(1000, 1, 0, 3);

    // Period shorter than the divider: alternate measurements dropped.
    fixed    = '{20, 7, 35, 1, 1'b0};
    n_phase  = 0;
    fixed_on = 1;
    repeat (30) begin
      pwm_period(20, 7, 35, 1);
      prev_valid = 0;
    end
    chk("overrun_set", int'(overrun), 1);
    chk_min("overrun_results", n_phase, 3);

    // Stuck low, then stuck high.
    wait_cyc(100);
    fixed   = '{TIMEOUT, 0, 0, 3, 1'b1};
    n_phase = 0;
    wait_cyc(9900);
    chk_min("stuck_low_count", n_phase, 2);
    pwm_in = 1'b1;
    wait_cyc(10);
    fixed   = '{TIMEOUT, TIMEOUT, 100, 2, 1'b1};
    n_phase = 0;
    wait_cyc(9990);
    chk_min("stuck_high_count", n_phase, 2);
    pwm_in = 1'b0;
    wait_cyc(10);
    fixed_on = 0;
    wait_cyc(490);

    // Toggling again gives normal results with stuck=0.
    repeat (3) pwm_period(1000, 500, 50, 1);
    chk("overrun_sticky", int'(overrun), 1);

    // Drop enable mid-divide: no result, outputs held.
    prev_valid = 0;
    pwm_in = 1'b1;
    wait_cyc(10);
    enable = 1'b0;
    wait_cyc(290);
    pwm_in = 1'b0;
    wait_cyc(100);
    chk("held_period", int'(period), last_exp.per);
    chk("held_high", int'(high_time), last_exp.hi);
    chk("held_duty", int'(duty_pct), last_exp.duty);
    chk("held_band", int'(band), last_exp.bnd);
    chk("held_stuck", int'(stuck), int'(last_exp.stk));
    enable = 1'b1;
    wait_cyc(200);

    // Asynchronous reset mid-period while the line is low.
    #3 rst = 1'b0;
    #1 chk_zero("midrst");
    wait_cyc(100);
    rst = 1'b1;
    wait_cyc(300);
    repeat (3) pwm_period(1000, 250, 25, 0);

    for (int i = 0; i < 300 && q.size() != 0; i++) wait_cyc(1);
    chk("queue_drained", q.size(), 0);
    chk("overrun_after_rst", int'(overrun), 0);
    chk("no_x", x_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
